// File: rtl/pmod_bridge_pkg.sv
// ============================================================================
// Module : pmod_bridge_pkg
// Brief  : Shared types, constants and baud helper for the PMOD UART bridge.
//          Optional macro PMOD_BRIDGE_PARITY_EN widens frames with even parity.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pmod_bridge_pkg;

    typedef enum logic [2:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP,
        R_WAIT_HIGH
    } rx_state_t;

    typedef enum logic [1:0] {
        T_IDLE,
        T_START,
        T_DATA,
        T_STOP
    } tx_state_t;

    localparam logic UART_IDLE = 1'b1;
    localparam int   DATA_BITS = 8;

`ifdef PMOD_BRIDGE_PARITY_EN
    localparam int FRAME_BITS = DATA_BITS + 1;
`else
    localparam int FRAME_BITS = DATA_BITS;
`endif
    localparam int IDX_W = $clog2(FRAME_BITS);

    function automatic int calc_clks_per_bit(input int clk_hz, input int baud);
        int cpb;
        cpb = clk_hz / baud;
        if (cpb < 4) cpb = 4;
        return cpb;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_serializer.sv
// ============================================================================
// Module : uart_tx_serializer
// Brief  : Start/data/(parity)/stop serializer; PMOD_BRIDGE_PARITY_EN adds an
//          even-parity bit after data bit 7.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk_100mhz,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       busy,
    output logic       tx
);
    import pmod_bridge_pkg::*;

    localparam int                CNT_W    = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0]  BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(FRAME_BITS - 1);

    tx_state_t              state, state_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic [IDX_W-1:0]       idx, idx_nxt;
    logic [FRAME_BITS-1:0]  snap, snap_nxt;
    logic [FRAME_BITS-1:0]  frame_word;
    logic                   tx_nxt;
    logic                   bit_done;

`ifdef PMOD_BRIDGE_PARITY_EN
    assign frame_word = {^data, data};
`else
    assign frame_word = data;
`endif

    assign bit_done = (cnt == BIT_LAST);
    assign busy     = (state != T_IDLE);

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            state <= T_IDLE;
            cnt   <= '0;
            idx   <= '0;
            snap  <= '0;
            tx    <= UART_IDLE;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            snap  <= snap_nxt;
            tx    <= tx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        idx_nxt   = idx;
        snap_nxt  = snap;
        tx_nxt    = UART_IDLE;
        case (state)
            T_IDLE: begin
                if (start) begin
                    state_nxt = T_START;
                    snap_nxt  = frame_word;
                end
            end
            T_START: begin
                if (bit_done) begin
                    state_nxt = T_DATA;
                    idx_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            T_DATA: begin
                if (bit_done) begin
                    if (idx == IDX_LAST) state_nxt = T_STOP;
                    else                 idx_nxt   = idx + 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            T_STOP: begin
                if (bit_done) state_nxt = T_IDLE;
                else          cnt_nxt   = cnt + 1'b1;
            end
        endcase
        // Line level is registered from the upcoming state so tx never glitches.
        case (state_nxt)
            T_START: tx_nxt = 1'b0;
            T_DATA:  tx_nxt = snap_nxt[idx_nxt];
            default: tx_nxt = UART_IDLE;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/pmod_uart_bridge.sv
// ============================================================================
// Module : pmod_uart_bridge
// Brief  : Host UART <-> micro1 ui_in/uo_out bridge with change/echo reporting.
//          PMOD_BRIDGE_PARITY_EN enables even parity in both directions.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pmod_uart_bridge #(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 115_200
) (
    input  logic       clk_100mhz,
    input  logic       rst_n,
    input  logic       uart_rx,
    output logic       uart_tx,
    output logic [7:0] ui_out,
    input  logic [7:0] uo_in,
    output logic       rx_valid,
    output logic       rx_err
);
    import pmod_bridge_pkg::*;

    localparam int               CLKS_PER_BIT = calc_clks_per_bit(CLK_HZ, BAUD);
    localparam int               CNT_W        = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] BIT_LAST     = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_CNT     = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(FRAME_BITS - 1);

    logic [1:0]             sync;
    logic                   rx_s, rx_prev;
    rx_state_t              rx_state, rx_state_nxt;
    logic [CNT_W-1:0]       rx_cnt, rx_cnt_nxt;
    logic [IDX_W-1:0]       rx_idx, rx_idx_nxt;
    logic [FRAME_BITS-1:0]  rx_shift, rx_shift_nxt;
    logic                   rx_bit_done, parity_ok;
    logic                   commit, frame_err;

    logic [7:0]             last_sent;
    logic                   pending, tx_busy, tx_start;

    assign rx_s        = sync[1];
    assign rx_bit_done = (rx_cnt == BIT_LAST);

`ifdef PMOD_BRIDGE_PARITY_EN
    assign parity_ok = ~(^rx_shift);
`else
    assign parity_ok = 1'b1;
`endif

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            sync     <= {2{UART_IDLE}};
            rx_prev  <= UART_IDLE;
            rx_state <= R_IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_shift <= '0;
            ui_out   <= 8'h00;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
        end else begin
            sync     <= {sync[0], uart_rx};
            rx_prev  <= rx_s;
            rx_state <= rx_state_nxt;
            rx_cnt   <= rx_cnt_nxt;
            rx_idx   <= rx_idx_nxt;
            rx_shift <= rx_shift_nxt;
            rx_valid <= commit;
            if (commit)    ui_out <= rx_shift[DATA_BITS-1:0];
            if (frame_err) rx_err <= 1'b1;
        end
    end

    always_comb begin
        rx_state_nxt = rx_state;
        rx_cnt_nxt   = '0;
        rx_idx_nxt   = rx_idx;
        rx_shift_nxt = rx_shift;
        commit       = 1'b0;
        frame_err    = 1'b0;
        case (rx_state)
            R_IDLE: begin
                if (rx_prev && !rx_s) rx_state_nxt = R_START;
            end
            R_START: begin
                // Mid-start sample rejects short low glitches silently.
                if (rx_cnt == HALF_CNT) begin
                    rx_state_nxt = rx_s ? R_IDLE : R_DATA;
                    rx_idx_nxt   = '0;
                end else begin
                    rx_cnt_nxt = rx_cnt + 1'b1;
                end
            end
            R_DATA: begin
                if (rx_bit_done) begin
                    rx_shift_nxt = {rx_s, rx_shift[FRAME_BITS-1:1]};
                    if (rx_idx == IDX_LAST) rx_state_nxt = R_STOP;
                    else                    rx_idx_nxt   = rx_idx + 1'b1;
                end else begin
                    rx_cnt_nxt = rx_cnt + 1'b1;
                end
            end
            R_STOP: begin
                if (rx_bit_done) begin
                    if (!rx_s) begin
                        frame_err    = 1'b1;
                        rx_state_nxt = R_WAIT_HIGH;
                    end else begin
                        rx_state_nxt = R_IDLE;
                        commit       = parity_ok;
                        frame_err    = !parity_ok;
                    end
                end else begin
                    rx_cnt_nxt = rx_cnt + 1'b1;
                end
            end
            R_WAIT_HIGH: begin
                if (rx_s) rx_state_nxt = R_IDLE;
            end
            default: rx_state_nxt = R_IDLE;
        endcase
    end

    // Triggers coalesce into one flag; the value is sampled at launch.
    assign tx_start = pending && !tx_busy;

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            pending   <= 1'b0;
            last_sent <= 8'h00;
        end else if (tx_start) begin
            pending   <= 1'b0;
            last_sent <= uo_in;
        end else if ((uo_in != last_sent) || rx_valid) begin
            pending   <= 1'b1;
        end
    end

    uart_tx_serializer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx (
        .clk_100mhz (clk_100mhz),
        .rst_n      (rst_n),
        .start      (tx_start),
        .data       (uo_in),
        .busy       (tx_busy),
        .tx         (uart_tx)
    );

endmodule

`default_nettype wire

// File: tb/tb_pmod_uart_bridge.sv
// ============================================================================
// Module : tb_pmod_uart_bridge
// Brief  : Self-checking bench: fast-baud instance for function, default-baud
//          instance for idle, glitch and full-rate reception.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pmod_uart_bridge;

    localparam int FCPB = 10;
    localparam int SCPB = 868;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       f_rst_n, f_rx, f_tx, f_valid, f_err;
    logic [7:0] f_ui, f_uo;
    logic       s_rst_n, s_rx, s_tx, s_valid, s_err;
    logic [7:0] s_ui, s_uo;

    pmod_uart_bridge #(.CLK_HZ(100_000_000), .BAUD(10_000_000)) u_fast (
        .clk_100mhz (clk),
        .rst_n      (f_rst_n),
        .uart_rx    (f_rx),
        .uart_tx    (f_tx),
        .ui_out     (f_ui),
        .uo_in      (f_uo),
        .rx_valid   (f_valid),
        .rx_err     (f_err)
    );

    pmod_uart_bridge u_slow (
        .clk_100mhz (clk),
        .rst_n      (s_rst_n),
        .uart_rx    (s_rx),
        .uart_tx    (s_tx),
        .ui_out     (s_ui),
        .uo_in      (s_uo),
        .rx_valid   (s_valid),
        .rx_err     (s_err)
    );

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // rx_valid pulse monitors
    int   f_pulses = 0, f_wide = 0, s_pulses = 0;
    logic f_prev_valid = 1'b0;
    always @(negedge clk) begin
        if (f_valid) f_pulses++;
        if (f_valid && f_prev_valid) f_wide++;
        f_prev_valid <= f_valid;
        if (s_valid) s_pulses++;
    end

    // Fast TX line decoder: mid-bit sampling, frames cut by reset are dropped
    int         tx_frames = 0;
    logic [7:0] tx_log [256];
    initial begin
        logic       prev, ok;
        logic [7:0] b;
        prev = 1'b1;
        b    = 8'h00;
        forever begin
            @(negedge clk);
            if (f_rst_n && prev && !f_tx) begin
                ok = 1'b1;
                repeat (FCPB / 2) @(negedge clk);
                if (f_tx !== 1'b0 || !f_rst_n) ok = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    repeat (FCPB) @(negedge clk);
                    b[i] = f_tx;
                    if (!f_rst_n) ok = 1'b0;
                end
                repeat (FCPB) @(negedge clk);
                if (f_tx !== 1'b1 || !f_rst_n) ok = 1'b0;
                if (ok) begin
                    tx_log[tx_frames[7:0]] = b;
                    tx_frames++;
                end
            end
            prev = f_tx;
        end
    end

    task automatic set_line(input bit slow, input logic v);
        if (slow) s_rx = v;
        else      f_rx = v;
    endtask

    task automatic send_byte(input bit slow, input logic [7:0] b, input logic stop_bit);
        int cpb;
        cpb = slow ? SCPB : FCPB;
        @(negedge clk);
        set_line(slow, 1'b0);
        repeat (cpb) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            set_line(slow, b[i]);
            repeat (cpb) @(negedge clk);
        end
        set_line(slow, stop_bit);
        repeat (cpb) @(negedge clk);
        set_line(slow, 1'b1);
        repeat (8) @(negedge clk);
    endtask

    task automatic wait_frames(input string name, input int target);
        int k;
        k = 0;
        while (tx_frames < target && k < 400) begin
            @(negedge clk);
            k++;
        end
        repeat (150) @(negedge clk);
        check(name, tx_frames, target);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic [7:0] exp_ui;
        logic       exp_valid;
        logic       exp_err;
    } vec_t;

    vec_t       vecs [5];
    int         base, pbase, wbase, lows;
    logic [7:0] last_reported, uo_new, rbyte;

    initial begin
        vecs[0] = '{data: 8'hA5, stop: 1'b1, exp_ui: 8'hA5, exp_valid: 1'b1, exp_err: 1'b0};
        vecs[1] = '{data: 8'hFF, stop: 1'b0, exp_ui: 8'hA5, exp_valid: 1'b0, exp_err: 1'b1};
        vecs[2] = '{data: 8'h01, stop: 1'b1, exp_ui: 8'h01, exp_valid: 1'b1, exp_err: 1'b1};
        vecs[3] = '{data: 8'h80, stop: 1'b1, exp_ui: 8'h80, exp_valid: 1'b1, exp_err: 1'b1};
        vecs[4] = '{data: 8'h00, stop: 1'b0, exp_ui: 8'h80, exp_valid: 1'b0, exp_err: 1'b1};

        f_rst_n = 1'b0; s_rst_n = 1'b0;
        f_rx = 1'b1; s_rx = 1'b1;
        f_uo = 8'h00; s_uo = 8'h00;
        repeat (4) @(negedge clk);
        check("reset_tx", f_tx, 1'b1);
        check("reset_ui", f_ui, 8'h00);
        check("reset_valid", f_valid, 1'b0);
        check("reset_err", f_err, 1'b0);
        f_rst_n = 1'b1; s_rst_n = 1'b1;

        // Idle after reset on the full-rate instance
        lows = 0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (!s_tx) lows++;
        end
        check("idle_tx_lows", lows, 0);
        check("idle_ui", s_ui, 8'h00);
        check("idle_err", s_err, 1'b0);
        check("idle_pulses", s_pulses, 0);

        // Short low glitch, well under half a bit
        s_rx = 1'b0;
        repeat (200) @(negedge clk);
        s_rx = 1'b1;
        repeat (2000) @(negedge clk);
        check("glitch_pulses", s_pulses, 0);
        check("glitch_err", s_err, 1'b0);
        check("glitch_ui", s_ui, 8'h00);
        check("glitch_tx", s_tx, 1'b1);

        // Full-rate byte and the echo launch
        send_byte(1'b1, 8'hA5, 1'b1);
        check("slow_ui", s_ui, 8'hA5);
        check("slow_pulses", s_pulses, 1);
        lows = 0;
        for (int i = 0; i < 20 && lows == 0; i++) begin
            @(negedge clk);
            if (!s_tx) lows = 1;
        end
        check("slow_echo_launch", lows, 1);

        // uo_in change alone reports 3C
        base = tx_frames;
        f_uo = 8'h3C;
        wait_frames("uo_change_count", base + 1);
        check("uo_change_val", tx_log[base[7:0]], 8'h3C);

        // Table vectors: reception, stop errors, echo reporting
        for (int v = 0; v < 5; v++) begin
            base  = tx_frames;
            pbase = f_pulses;
            wbase = f_wide;
            send_byte(1'b0, vecs[v].data, vecs[v].stop);
            check($sformatf("vec%0d_ui", v), f_ui, vecs[v].exp_ui);
            check($sformatf("vec%0d_err", v), f_err, vecs[v].exp_err);
            check($sformatf("vec%0d_pulses", v), f_pulses - pbase, vecs[v].exp_valid ? 1 : 0);
            check($sformatf("vec%0d_wide", v), f_wide - wbase, 0);
            wait_frames($sformatf("vec%0d_echo_count", v), base + (vecs[v].exp_valid ? 1 : 0));
            if (vecs[v].exp_valid)
                check($sformatf("vec%0d_echo_val", v), tx_log[base[7:0]], 8'h3C);
        end

        // Changes while busy coalesce; value taken at launch
        base = tx_frames;
        @(negedge clk);
        f_uo = 8'h11;
        repeat (30) @(negedge clk);
        f_uo = 8'h22;
        repeat (20) @(negedge clk);
        f_uo = 8'h33;
        wait_frames("coalesce_count", base + 2);
        check("coalesce_first", tx_log[base[7:0]], 8'h11);
        check("coalesce_second", tx_log[(base + 1) & 255], 8'h33);

        // Randomized traffic against a report-on-change / echo-per-byte model
        last_reported = 8'h33;
        for (int it = 0; it < 20; it++) begin
            uo_new = 8'($urandom_range(0, 255));
            rbyte  = 8'($urandom_range(0, 255));
            base   = tx_frames;
            f_uo   = uo_new;
            if (uo_new != last_reported) begin
                wait_frames($sformatf("rnd%0d_chg_count", it), base + 1);
                check($sformatf("rnd%0d_chg_val", it), tx_log[base[7:0]], uo_new);
                last_reported = uo_new;
            end
            base  = tx_frames;
            pbase = f_pulses;
            send_byte(1'b0, rbyte, 1'b1);
            check($sformatf("rnd%0d_ui", it), f_ui, rbyte);
            check($sformatf("rnd%0d_pulse", it), f_pulses - pbase, 1);
            wait_frames($sformatf("rnd%0d_echo_count", it), base + 1);
            check($sformatf("rnd%0d_echo_val", it), tx_log[base[7:0]], uo_new);
        end

        // Reset during RX data bit 4
        f_uo = 8'h00;
        repeat (300) @(negedge clk);
        send_byte(1'b0, 8'hC3, 1'b1);
        repeat (300) @(negedge clk);
        @(negedge clk);
        f_rx = 1'b0;
        repeat (FCPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            f_rx = 1'(8'h5A >> i);
            repeat (FCPB) @(negedge clk);
        end
        f_rx = 1'b1;
        repeat (FCPB / 2) @(negedge clk);
        f_rst_n = 1'b0;
        #1;
        check("rst_rx_tx", f_tx, 1'b1);
        check("rst_rx_ui", f_ui, 8'h00);
        check("rst_rx_err", f_err, 1'b0);
        repeat (120) @(negedge clk);
        f_rst_n = 1'b1;
        base  = tx_frames;
        pbase = f_pulses;
        send_byte(1'b0, 8'h5A, 1'b1);
        check("rst_rx_after_ui", f_ui, 8'h5A);
        check("rst_rx_after_pulse", f_pulses - pbase, 1);
        wait_frames("rst_rx_echo_count", base + 1);
        check("rst_rx_echo_val", tx_log[base[7:0]], 8'h00);

        // Reset during TX data bit 4; last_sent returns to 00 so 77 is re-reported
        base = tx_frames;
        @(negedge clk);
        f_uo = 8'h77;
        repeat (2 + FCPB + 4 * FCPB + FCPB / 2) @(negedge clk);
        f_rst_n = 1'b0;
        #1;
        check("rst_tx_line", f_tx, 1'b1);
        check("rst_tx_ui", f_ui, 8'h00);
        repeat (120) @(negedge clk);
        check("rst_tx_no_partial", tx_frames, base);
        f_rst_n = 1'b1;
        wait_frames("rst_tx_after_count", base + 1);
        check("rst_tx_after_val", tx_log[base[7:0]], 8'h77);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pmod_uart_bridge.md
Name: pmod_uart_bridge

Overview:
- Host-side stage for the micro1 FPGA build. Sits upstream of micro1 `ui_in` and downstream of micro1 `uo_out`.
- Receives bytes from a host UART and drives them onto the 8-bit `ui_in` bus.
- Reports the 8-bit `uo_out` value back to the host on change, and on every received byte.
- Runs on the board 100 MHz clock. Same clock domain as micro1.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz.
- BAUD, 115200, UART bit rate.
- CLKS_PER_BIT, CLK_HZ/BAUD (868), clocks per bit. Derived localparam; minimum 4.

Ports:
- clk_100mhz  in  1  system clock.
- rst_n  in  1  reset. Asynchronous assert, active-low.
- uart_rx  in  1  host serial input. Asynchronous; idles high.
- uart_tx  out  1  host serial output. Idles high.
- ui_out  out  8  drives micro1 `ui_in`.
- uo_in  in  8  observes micro1 `uo_out`. Same clock domain.
- rx_valid  out  1  one-cycle pulse when ui_out updates.
- rx_err  out  1  sticky framing/parity error flag.

Behaviour:
- Clock and reset:
  - One clock.
  - Reset is asynchronous, active-low.
- Reset values:
  - uart_tx=1, ui_out=8'h00, rx_valid=0, rx_err=0.
  - Both synchronizer flops=1, last_sent=8'h00, pending=0.
  - RX FSM=R_IDLE, TX FSM=T_IDLE.
- Reset mid-frame: abort immediately. Line returns high; no partial byte is committed.
- RX input conditioning: uart_rx passes through a 2-flop synchronizer before any use.
- RX FSM states: R_IDLE, R_START, R_DATA, R_STOP, R_WAIT_HIGH.
  - R_IDLE: a synchronized 1->0 transition starts a counter and moves to R_START.
  - R_START: at count CLKS_PER_BIT/2 (434), sample the line.
    - Low: enter R_DATA.
    - High: glitch; return to R_IDLE with no error.
  - R_DATA: sample 8 bits LSB-first, each CLKS_PER_BIT after the previous sample.
  - R_STOP: sample the stop bit.
    - 1: on the next cycle, ui_out takes the byte and rx_valid pulses for exactly 1 cycle. Return to R_IDLE.
    - 0: set rx_err; ui_out is unchanged; go to R_WAIT_HIGH.
  - R_WAIT_HIGH: return to R_IDLE once the synchronized line is 1.
- rx_err is cleared only by reset.
- Back-to-back RX frames with no idle gap are accepted. A start edge is seen in R_IDLE on the first cycle after the stop sample.
- TX trigger: `pending` is set when either:
  - uo_in != last_sent, or
  - a rx_valid pulse occurs (echo-read).
- TX FSM states: T_IDLE, T_START, T_DATA, T_STOP.
  - T_IDLE with pending=1: latch snap=uo_in, set last_sent=uo_in, clear pending, enter T_START on the same cycle.
  - Frame: start bit 0, 8 data bits LSB-first, stop bit 1. Each bit is held CLKS_PER_BIT clocks.
  - After the stop bit, return to T_IDLE. One frame = 10*CLKS_PER_BIT clocks.
- Changes during a TX frame:
  - Any uo_in changes or rx_valid pulses while busy coalesce into a single pending flag.
  - The value sent is uo_in at launch time, not at trigger time.
  - If uo_in returns to last_sent before launch and there was no rx_valid, pending stays set; one redundant frame is allowed.
- Simultaneous rx_valid and uo_in change: a single pending set, producing one frame.
- Arithmetic: counters are $clog2(CLKS_PER_BIT)+1 bits wide. Bit index is 3 bits (4 with parity). No wrap beyond the terminal count.

Optional Feature:
- Macro: PMOD_BRIDGE_PARITY_EN.
- When defined:
  - An even-parity bit is inserted after data bit 7 in both directions. Frame is 11 bits.
  - On RX, a parity mismatch sets rx_err and discards the byte: no ui_out update, no rx_valid. The stop bit is still checked.
  - TX emits the even parity of snap.
- When undefined: 8N1 only. No parity logic is present.

Decomposition:
- Package pmod_bridge_pkg holds:
  - rx_state_t and tx_state_t enums.
  - Function calc_clks_per_bit(CLK_HZ, BAUD).
  - Constants UART_IDLE=1'b1 and DATA_BITS=8.
- One sub-module: uart_tx_serializer.
  - Ports: clk_100mhz, rst_n, start, data[7:0], busy, tx.
  - Owns the TX FSM and bit counter.
  - The top keeps the RX FSM, synchronizer, pending and last_sent logic.

Test Plan (CLKS_PER_BIT=868; use BAUD override 10 Mbaud, CLKS_PER_BIT=10, for speed where noted):
1. Reset release with uo_in=8'h00 held:
   - uart_tx stays 1 for 20000 cycles.
   - ui_out=00, rx_err=0, no frame.
2. Host sends 8'hA5 (8N1):
   - ui_out=A5 one cycle after the stop-bit sample; rx_valid high exactly 1 cycle.
   - uart_tx then sends the current uo_in (e.g. 3C): bits 0,0,0,1,1,1,1,0,0,1.
3. uo_in steps 00->11, then 11->22 mid-frame, then 22->33, all while TX is busy:
   - Exactly two frames: 11, then 33.
4. Stop bit driven 0 on byte 8'hFF:
   - rx_err=1 sticky; ui_out unchanged; no rx_valid.
   - Next valid byte 8'h01 still updates ui_out=01 while rx_err stays 1.
5. 200-cycle low glitch on uart_rx (< 434):
   - No state change, no rx_err, no rx_valid.
6. Assert rst_n low at data bit 4 of an RX frame and of a TX frame (CLKS_PER_BIT=10):
   - Immediate uart_tx=1, ui_out=00.
   - After release, the next full byte 8'h5A is received correctly.
